hdlc_protocol_checker: RTL
==========================

HDLC_PROTOCOL_CHECKER -- requirements
Module: hdlc_protocol_checker

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of independent monitored HDLC channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 16: width of the saturating error counter.
REQ-003 SHALL have parameter FLAG_LAT, default 2: required flag-to-FlagDetect latency, in cycles.
REQ-004 SHALL have parameter ABORT_LAT, default 2: maximum abort-to-AbortSignal latency, in cycles (1..7).
REQ-005 SHALL have parameter IDLE_LEN, default 8: number of ValidFrame-low cycles after which the line must idle high.
REQ-006 SHALL have ports:
- Clk  in  1  single clock; all logic on rising edge.
- Rst  in  1  synchronous, active-high reset.
- Enable  in  1  global check enable.
- ClearCnt  in  1  clears ErrCnt and ErrFlag.
- IdleChkEn  in  N_CH  per-channel idle-rule enable.
- Line  in  N_CH  serial bit per channel.
- ValidFrame  in  N_CH  DUT frame-valid per channel.
- FlagDetect  in  N_CH  DUT flag indication, under check.
- AbortSignal  in  N_CH  DUT abort indication, under check.
- ErrFlag  out  N_CH*4  sticky per-channel, per-rule error bits; index = ch*4+rule.
- ErrCnt  out  CNT_W  total error events, saturating.
- ErrValid  out  1  one-cycle pulse in any cycle in which at least one error is raised.
- ErrChan  out  clog2(N_CH), minimum 1  lowest channel raising an error this cycle.

Function
REQ-007 SHALL keep, per channel, an 8-bit history of sampled Line bits and a ones-run counter that saturates at 7 and is zeroed by a 0.
REQ-008 SHALL recognise a flag on the cycle t in which the history equals 0,1,1,1,1,1,1,0 (oldest first).
REQ-009 Rule FLAG (0): SHALL raise an error at cycle t+FLAG_LAT if FlagDetect is low in that cycle; this check uses a FLAG_LAT-deep pipeline, and overlapping flags are each checked.
REQ-010 SHALL run a per-channel FSM with states IDLE, FRAME and ABORT_WAIT:
- IDLE->FRAME when ValidFrame=1.
- FRAME->IDLE when ValidFrame=0.
- FRAME->ABORT_WAIT when the ones-run reaches 7 while ValidFrame=1; this loads timer=ABORT_LAT.
REQ-011 Rule ABORT (1): in ABORT_WAIT, AbortSignal=1 SHALL move the FSM to IDLE; otherwise the timer decrements, and the SHALL raise an error and move to IDLE when the timer reaches 0 without AbortSignal.
REQ-012 Rule SPURIOUS (2): SHALL raise an error on an AbortSignal 0->1 edge when no abort (7 ones in frame) was recognised in the preceding ABORT_LAT cycles.
REQ-013 Rule IDLE (3): SHALL count consecutive ValidFrame=0 cycles, saturating at IDLE_LEN; when the count equals IDLE_LEN, IdleChkEn=1 and Line=0, SHALL raise an error; ValidFrame=1 zeroes the count.
REQ-014 SHALL set ErrFlag[ch*4+rule] on each error; the bit holds until ClearCnt or Rst.
REQ-015 SHALL add the number of (channel, rule) errors raised in a cycle to ErrCnt, saturating at all-ones.
REQ-016 When ClearCnt coincides with errors, SHALL clear first, so ErrCnt = new-event count and ErrFlag = new bits only.
REQ-017 ErrValid and ErrChan SHALL be registered, valid in the cycle after the error; ErrChan SHALL report the lowest-index channel.
REQ-018 With Enable=0, SHALL raise no errors, hold FSMs in IDLE, clear histories, pipelines and idle counters, and retain ErrCnt and ErrFlag.
REQ-019 An all-zero history after reset SHALL NOT be recognised as a flag.

Reset
REQ-020 Rst=1 SHALL zero ErrFlag, ErrCnt, ErrValid, ErrChan, all histories, ones-runs, flag pipelines, timers and idle counters, and force all FSMs to IDLE.
REQ-021 Rst asserted mid-frame or mid-ABORT_WAIT SHALL discard all pending checks; no error is raised for them.

Structure
REQ-022 Package hdlc_chk_pkg SHALL hold the rule enum (RULE_FLAG=0, RULE_ABORT=1, RULE_SPURIOUS=2, RULE_IDLE=3), NUM_RULES=4 and the FSM state typedef.
REQ-023 Sub-module hdlc_chk_channel SHALL implement one channel (history, FSM, rules) and output a 4-bit error vector; the top generates N_CH instances plus the counter and reporting logic.

Verification
REQ-024 Flag on ch0: Line 0,1,1,1,1,1,1,0 with FlagDetect high 2 cycles after the last 0 -> no error; FlagDetect held low instead -> ErrFlag[0]=1, ErrCnt=1, ErrChan=0.
REQ-025 Abort on ch1: ValidFrame=1 and 7 ones; AbortSignal at +2 -> no error; AbortSignal never -> ErrFlag[5]=1 at +2.
REQ-026 Spurious: AbortSignal pulses on ch1 with no preceding ones -> ErrFlag[6]=1, ErrCnt increments by 1.
REQ-027 Idle: ValidFrame=0 for 8 cycles, IdleChkEn=1, then Line=0 -> ErrFlag[3]=1; the same stimulus with IdleChkEn=0 -> no error.
REQ-028 Simultaneous and saturating: both channels miss FlagDetect in the same cycle -> ErrCnt += 2 and ErrChan=0; CNT_W=2 with 5 errors -> ErrCnt=3; ClearCnt coinciding with 1 error -> ErrCnt=1.
REQ-029 Rst pulsed during ABORT_WAIT -> no ABORT error raised and all outputs zero.

Source files
------------

// File: rtl/hdlc_chk_pkg.sv
// Shared types and constants for the HDLC protocol checker.
package hdlc_chk_pkg;

    localparam int NUM_RULES = 4;

    // Bit position of each rule inside a channel's error vector.
    typedef enum logic [1:0] {
        RULE_FLAG     = 2'd0,
        RULE_ABORT    = 2'd1,
        RULE_SPURIOUS = 2'd2,
        RULE_IDLE     = 2'd3
    } rule_e;

    // Per-channel frame tracking state.
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_FRAME      = 2'd1,
        ST_ABORT_WAIT = 2'd2
    } state_e;

    // HDLC flag 0,1,1,1,1,1,1,0 with the oldest bit in the MSB.
    localparam logic [7:0] FLAG_PATTERN = 8'b0111_1110;

endpackage

// File: rtl/hdlc_chk_channel.sv
// One monitored HDLC channel: line history, frame FSM and the four rule checks.
// Errors are combinational for the current cycle; the top registers them.
module hdlc_chk_channel
    import hdlc_chk_pkg::*;
#(
    parameter int FLAG_LAT  = 2,
    parameter int ABORT_LAT = 2,
    parameter int IDLE_LEN  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 idle_chk_en,
    input  logic                 line,
    input  logic                 valid_frame,
    input  logic                 flag_detect,
    input  logic                 abort_signal,
    output logic [NUM_RULES-1:0] err
);

    localparam int                IDLE_W     = $clog2(IDLE_LEN + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX   = IDLE_W'(IDLE_LEN);
    localparam logic [2:0]        ABORT_INIT = 3'(ABORT_LAT);

    logic [7:0]          hist;
    logic [2:0]          ones_run;
    logic [FLAG_LAT-1:0] flag_pipe;
    state_e              state;
    logic [2:0]          timer;
    logic [2:0]          abort_win;
    logic                abort_d;
    logic [IDLE_W-1:0]   idle_cnt;

    logic flag_hit;
    logic abort_seen;
    logic abort_rise;

    // Flag seen in the registered history; the 7th one arriving inside a frame is an abort.
    assign flag_hit   = (hist == FLAG_PATTERN);
    assign abort_seen = (state == ST_FRAME) && valid_frame && (ones_run == 3'd6) && line;
    assign abort_rise = abort_signal && !abort_d;

    // Evaluate the four rules for the current cycle.
    always_comb begin
        // NOTE: default every output first so no path through the block can infer a latch.
        err                = '0;
        err[RULE_FLAG]     = enable && flag_pipe[FLAG_LAT-1] && !flag_detect;
        err[RULE_ABORT]    = enable && (state == ST_ABORT_WAIT) && !abort_signal && (timer == 3'd1);
        err[RULE_SPURIOUS] = enable && abort_rise && (abort_win == 3'd0);
        err[RULE_IDLE]     = enable && idle_chk_en && !line && (idle_cnt == IDLE_MAX);
    end

    // History, run counters, flag pipeline, abort window, idle counter and frame FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: all state uses non-blocking assignment so every register sees pre-edge values.
            hist      <= '0;
            ones_run  <= '0;
            flag_pipe <= '0;
            state     <= ST_IDLE;
            timer     <= '0;
            abort_win <= '0;
            abort_d   <= 1'b0;
            idle_cnt  <= '0;
        end else begin
            abort_d <= abort_signal;
            if (!enable) begin
                hist      <= '0;
                ones_run  <= '0;
                flag_pipe <= '0;
                state     <= ST_IDLE;
                timer     <= '0;
                abort_win <= '0;
                idle_cnt  <= '0;
            end else begin
                hist     <= {hist[6:0], line};
                ones_run <= line ? ((ones_run == 3'd7) ? 3'd7 : ones_run + 3'd1) : 3'd0;

                flag_pipe[0] <= flag_hit;
                for (int i = 1; i < FLAG_LAT; i++) begin
                    flag_pipe[i] <= flag_pipe[i-1];
                end

                // Window in which a rising AbortSignal is justified by a recent abort.
                if (abort_seen)
                    abort_win <= ABORT_INIT;
                else if (abort_win != 3'd0)
                    abort_win <= abort_win - 3'd1;

                if (valid_frame)
                    idle_cnt <= '0;
                else if (idle_cnt != IDLE_MAX)
                    idle_cnt <= idle_cnt + 1'b1;

                case (state)
                    ST_IDLE: begin
                        if (valid_frame)
                            state <= ST_FRAME;
                    end
                    ST_FRAME: begin
                        if (!valid_frame) begin
                            state <= ST_IDLE;
                        end else if (abort_seen) begin
                            state <= ST_ABORT_WAIT;
                            timer <= ABORT_INIT;
                        end
                    end
                    ST_ABORT_WAIT: begin
                        // Either the abort was reported or the last allowed cycle just expired.
                        if (abort_signal || timer <= 3'd1) begin
                            state <= ST_IDLE;
                            timer <= '0;
                        end else begin
                            timer <= timer - 3'd1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/hdlc_protocol_checker.sv
// Multi-channel HDLC protocol checker: per-channel rule checkers plus
// sticky error flags, a saturating event counter and error reporting.
module hdlc_protocol_checker
    import hdlc_chk_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int CNT_W     = 16,
    parameter int FLAG_LAT  = 2,
    parameter int ABORT_LAT = 2,
    parameter int IDLE_LEN  = 8
) (
    input  logic                                      Clk,
    input  logic                                      Rst,
    input  logic                                      Enable,
    input  logic                                      ClearCnt,
    input  logic [N_CH-1:0]                           IdleChkEn,
    input  logic [N_CH-1:0]                           Line,
    input  logic [N_CH-1:0]                           ValidFrame,
    input  logic [N_CH-1:0]                           FlagDetect,
    input  logic [N_CH-1:0]                           AbortSignal,
    output logic [N_CH*4-1:0]                         ErrFlag,
    output logic [CNT_W-1:0]                          ErrCnt,
    output logic                                      ErrValid,
    output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] ErrChan
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH*NUM_RULES-1:0] err_vec;
    logic [7:0]                ev_cnt;
    logic [CH_W-1:0]           first_ch;
    logic [CNT_W-1:0]          cnt_base;
    logic [CNT_W+7:0]          cnt_sum;
    logic [CNT_W-1:0]          cnt_next;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        hdlc_chk_channel #(
            .FLAG_LAT  (FLAG_LAT),
            .ABORT_LAT (ABORT_LAT),
            .IDLE_LEN  (IDLE_LEN)
        ) u_ch (
            .clk          (Clk),
            .rst          (Rst),
            .enable       (Enable),
            .idle_chk_en  (IdleChkEn[g]),
            .line         (Line[g]),
            .valid_frame  (ValidFrame[g]),
            .flag_detect  (FlagDetect[g]),
            .abort_signal (AbortSignal[g]),
            .err          (err_vec[g*NUM_RULES +: NUM_RULES])
        );
    end

    // Count this cycle's events, pick the lowest erroring channel, saturate the counter.
    always_comb begin
        ev_cnt = '0;
        for (int i = 0; i < N_CH*NUM_RULES; i++) begin
            ev_cnt = ev_cnt + {7'd0, err_vec[i]};
        end
        // Walk downwards so the lowest-index channel is the one left standing.
        first_ch = '0;
        for (int c = N_CH-1; c >= 0; c--) begin
            if (|err_vec[c*NUM_RULES +: NUM_RULES])
                first_ch = CH_W'(c);
        end
        // A coinciding clear applies first; this cycle's events then count from zero.
        cnt_base = ClearCnt ? '0 : ErrCnt;
        cnt_sum  = {8'd0, cnt_base} + {{CNT_W{1'b0}}, ev_cnt};
        cnt_next = (|cnt_sum[CNT_W+7:CNT_W]) ? '1 : cnt_sum[CNT_W-1:0];
    end

    // Register sticky flags, counter and the one-cycle error report.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            ErrFlag  <= '0;
            ErrCnt   <= '0;
            ErrValid <= 1'b0;
            ErrChan  <= '0;
        end else begin
            ErrFlag  <= (ClearCnt ? '0 : ErrFlag) | err_vec;
            ErrCnt   <= cnt_next;
            ErrValid <= |err_vec;
            ErrChan  <= first_ch;
        end
    end

endmodule
